// File: rtl/mdbrot_pkg.sv
// Shared types and helpers for the Mandelbrot renderer: Q4.28 fixed point,
// the viewport FSM state enum and a saturating add/sub.
package mdbrot_pkg;

    localparam int FRAC_BITS = 28;
    localparam int H_RES_DEF = 160;
    localparam int V_RES_DEF = 120;

    typedef logic signed [31:0] fixed_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNDS,
        ST_DIV_X,
        ST_DIV_Y,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic   ovf;
        fixed_t val;
    } sat_t;

    // 33-bit add/sub clipped to the Q4.28 range; ovf flags a clipped result.
    function automatic sat_t sat_addsub(input fixed_t a, input fixed_t b, input logic sub);
        logic [32:0] s;
        sat_t        r;
        if (sub) begin
            s = {a[31], a} - {b[31], b};
        end else begin
            s = {a[31], a} + {b[31], b};
        end
        r.ovf = s[32] ^ s[31];
        if (!r.ovf) begin
            r.val = s[31:0];
        end else if (s[32]) begin
            r.val = 32'h8000_0000;
        end else begin
            r.val = 32'h7FFF_FFFF;
        end
        return r;
    endfunction

endpackage

// File: rtl/mdbrot_viewport_calc_if.sv
// Request/result bundle between the renderer top level and the viewport calculator.
interface mdbrot_viewport_calc_if;
    import mdbrot_pkg::*;

    logic       start;
    fixed_t     center_x;
    fixed_t     center_y;
    logic [4:0] zoom_level;
    fixed_t     xmin;
    fixed_t     xmax;
    fixed_t     ymin;
    fixed_t     ymax;
    fixed_t     Xscale;
    fixed_t     Yscale;
    logic       busy;
    logic       done;
    logic       ovf;

    modport master (
        output start, center_x, center_y, zoom_level,
        input  xmin, xmax, ymin, ymax, Xscale, Yscale, busy, done, ovf
    );

    modport slave (
        input  start, center_x, center_y, zoom_level,
        output xmin, xmax, ymin, ymax, Xscale, Yscale, busy, done, ovf
    );
endinterface

// File: rtl/mdbrot_serial_div.sv
// Unsigned 32-bit / 8-bit restoring divider, one quotient bit per clock.
// The first bit is resolved on the go edge so valid rises 32 edges after go.
module mdbrot_serial_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [31:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        valid,
    output logic [31:0] quotient
);
    logic [7:0]  rem_r;
    logic [7:0]  div_r;
    logic [31:0] q_r;
    logic [4:0]  cnt_r;

    logic [7:0]  rem_src;
    logic [31:0] q_src;
    logic [7:0]  d_src;
    logic [8:0]  rem_sh;
    logic [8:0]  rem_diff;
    logic [7:0]  rem_nxt;
    logic [31:0] q_nxt;

    always_comb begin
        rem_src  = go ? 8'd0 : rem_r;
        q_src    = go ? dividend : q_r;
        d_src    = go ? divisor : div_r;
        rem_sh   = {rem_src, q_src[31]};
        rem_diff = rem_sh - {1'b0, d_src};
        if (rem_sh >= {1'b0, d_src}) begin
            rem_nxt = rem_diff[7:0];
            q_nxt   = {q_src[30:0], 1'b1};
        end else begin
            rem_nxt = rem_sh[7:0];
            q_nxt   = {q_src[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r <= '0;
            div_r <= '0;
            q_r   <= '0;
            cnt_r <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else if (go) begin
            rem_r <= rem_nxt;
            div_r <= divisor;
            q_r   <= q_nxt;
            cnt_r <= 5'd31;
            busy  <= 1'b1;
            valid <= 1'b0;
        end else if (cnt_r != 5'd0) begin
            rem_r <= rem_nxt;
            q_r   <= q_nxt;
            cnt_r <= cnt_r - 5'd1;
            busy  <= (cnt_r != 5'd1);
            valid <= (cnt_r == 5'd1);
        end else begin
            valid <= 1'b0;
        end
    end

    assign quotient = q_r;
endmodule

// File: rtl/mdbrot_viewport_calc.sv
// Converts a view centre and power-of-two zoom into window bounds and
// per-pixel step sizes for the 160x120 frame.
module mdbrot_viewport_calc
    import mdbrot_pkg::*;
#(
    parameter int          H_RES       = H_RES_DEF,
    parameter int          V_RES       = V_RES_DEF,
    parameter logic [31:0] BASE_HALF_W = 32'h2000_0000
) (
    input logic                   clk,
    input logic                   rst,
    mdbrot_viewport_calc_if.slave bus
);
    localparam logic [7:0] H_DIV = 8'(H_RES);
    localparam logic [7:0] V_DIV = 8'(V_RES);

    state_t      state, state_nxt;
    fixed_t      cx_r, cy_r;
    logic [4:0]  zoom_r;
    fixed_t      xmin_r, xmax_r, ymin_r, ymax_r, xscale_r, yscale_r;
    logic        busy_r, done_r, ovf_r;

    logic        capture, ld_x, ld_y, div_go;
    logic [31:0] div_dividend;
    logic [7:0]  div_divisor;
    logic        div_busy, div_valid;
    logic [31:0] div_quotient;

    logic [31:0] hw_u, hh_u;
    sat_t        s_xmin, s_xmax, s_ymin, s_ymax;

    // Half-height is 3/4 of the half-width, truncated, for the 4:3 frame.
    assign hw_u   = BASE_HALF_W >> zoom_r;
    assign hh_u   = (hw_u >> 1) + (hw_u >> 2);
    assign s_xmin = sat_addsub(cx_r, fixed_t'(hw_u), 1'b1);
    assign s_xmax = sat_addsub(cx_r, fixed_t'(hw_u), 1'b0);
    assign s_ymin = sat_addsub(cy_r, fixed_t'(hh_u), 1'b1);
    assign s_ymax = sat_addsub(cy_r, fixed_t'(hh_u), 1'b0);

    mdbrot_serial_div u_div (
        .clk      (clk),
        .rst      (rst),
        .go       (div_go),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .valid    (div_valid),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        capture      = 1'b0;
        ld_x         = 1'b0;
        ld_y         = 1'b0;
        div_go       = 1'b0;
        div_dividend = '0;
        div_divisor  = '0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    capture   = 1'b1;
                    state_nxt = ST_BOUNDS;
                end
            end
            ST_BOUNDS: begin
                // Widths come from the unsaturated half-sizes, not the clipped bounds.
                div_go       = 1'b1;
                div_dividend = hw_u << 1;
                div_divisor  = H_DIV;
                state_nxt    = ST_DIV_X;
            end
            ST_DIV_X: begin
                if (div_valid && !div_busy) begin
                    ld_x         = 1'b1;
                    div_go       = 1'b1;
                    div_dividend = hh_u << 1;
                    div_divisor  = V_DIV;
                    state_nxt    = ST_DIV_Y;
                end
            end
            ST_DIV_Y: begin
                if (div_valid && !div_busy) begin
                    ld_y      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.start) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cx_r     <= '0;
            cy_r     <= '0;
            zoom_r   <= '0;
            xmin_r   <= '0;
            xmax_r   <= '0;
            ymin_r   <= '0;
            ymax_r   <= '0;
            xscale_r <= '0;
            yscale_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (capture) begin
                cx_r   <= bus.center_x;
                cy_r   <= bus.center_y;
                zoom_r <= (bus.zoom_level > 5'd29) ? 5'd29 : bus.zoom_level;
                ovf_r  <= 1'b0;
            end
            if (state == ST_BOUNDS) begin
                xmin_r <= s_xmin.val;
                xmax_r <= s_xmax.val;
                ymin_r <= s_ymin.val;
                ymax_r <= s_ymax.val;
                ovf_r  <= s_xmin.ovf | s_xmax.ovf | s_ymin.ovf | s_ymax.ovf;
            end
            if (ld_x) begin
                xscale_r <= div_quotient;
            end
            if (ld_y) begin
                yscale_r <= div_quotient;
            end
            busy_r <= (state_nxt == ST_BOUNDS) || (state_nxt == ST_DIV_X) || (state_nxt == ST_DIV_Y);
            done_r <= (state_nxt == ST_DONE);
        end
    end

    assign bus.xmin   = xmin_r;
    assign bus.xmax   = xmax_r;
    assign bus.ymin   = ymin_r;
    assign bus.ymax   = ymax_r;
    assign bus.Xscale = xscale_r;
    assign bus.Yscale = yscale_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.ovf    = ovf_r;
endmodule

// File: tb/tb_mdbrot_viewport_calc.sv
// Randomized bench for mdbrot_viewport_calc against an arithmetic reference model.
module tb_mdbrot_viewport_calc;
    import mdbrot_pkg::*;

    localparam longint H = 160;
    localparam longint V = 120;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdbrot_viewport_calc_if vif();

    mdbrot_viewport_calc dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] e_xmin, e_xmax, e_ymin, e_ymax, e_xs, e_ys;
    logic        e_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] sat_ref(input longint v);
        if (v > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
        if (v < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        return {1'b0, v[31:0]};
    endfunction

    // Half-width at zoom 0 is 2.0 in Q4.28, i.e. 2^29.
    task automatic model(input logic [31:0] cx, input logic [31:0] cy, input logic [4:0] z);
        longint      hw, hh, cxl, cyl;
        int          zc;
        logic [32:0] r;
        zc    = (z > 5'd29) ? 29 : int'(z);
        hw    = longint'(1) << (29 - zc);
        hh    = hw / 2 + hw / 4;
        cxl   = longint'($signed(cx));
        cyl   = longint'($signed(cy));
        e_ovf = 1'b0;
        r = sat_ref(cxl - hw); e_xmin = r[31:0]; e_ovf |= r[32];
        r = sat_ref(cxl + hw); e_xmax = r[31:0]; e_ovf |= r[32];
        r = sat_ref(cyl - hh); e_ymin = r[31:0]; e_ovf |= r[32];
        r = sat_ref(cyl + hh); e_ymax = r[31:0]; e_ovf |= r[32];
        e_xs = 32'((2 * hw) / H);
        e_ys = 32'((2 * hh) / V);
    endtask

    task automatic check_outputs(input string name);
        check({name, ".xmin"},   vif.xmin,   e_xmin);
        check({name, ".xmax"},   vif.xmax,   e_xmax);
        check({name, ".ymin"},   vif.ymin,   e_ymin);
        check({name, ".ymax"},   vif.ymax,   e_ymax);
        check({name, ".Xscale"}, vif.Xscale, e_xs);
        check({name, ".Yscale"}, vif.Yscale, e_ys);
        check({name, ".ovf"},    32'(vif.ovf), 32'(e_ovf));
    endtask

    // Leaves start high; caller drops it.
    task automatic run_calc(input logic [31:0] cx, input logic [31:0] cy, input logic [4:0] z,
                            input string name);
        int n;
        model(cx, cy, z);
        @(negedge clk);
        vif.center_x   = cx;
        vif.center_y   = cy;
        vif.zoom_level = z;
        vif.start      = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) check({name, ".busy_e0"}, 32'(vif.busy), 32'd1);
            if (n == 2) check({name, ".xmin_e1"}, vif.xmin, e_xmin);
            check({name, ".busy_done_excl"}, 32'(vif.busy & vif.done), 32'd0);
            if (vif.done) break;
        end
        check({name, ".latency"}, 32'(n), 32'd66);
        check({name, ".busy_end"}, 32'(vif.busy), 32'd0);
        check_outputs(name);
    endtask

    task automatic drop_start(input string name);
        @(negedge clk);
        vif.start = 1'b0;
        @(posedge clk);
        #1;
        check({name, ".done_drop"}, 32'(vif.done), 32'd0);
    endtask

    task automatic check_zero(input string name);
        check({name, ".xmin"},   vif.xmin,   32'd0);
        check({name, ".xmax"},   vif.xmax,   32'd0);
        check({name, ".ymin"},   vif.ymin,   32'd0);
        check({name, ".ymax"},   vif.ymax,   32'd0);
        check({name, ".Xscale"}, vif.Xscale, 32'd0);
        check({name, ".Yscale"}, vif.Yscale, 32'd0);
        check({name, ".busy"},   32'(vif.busy), 32'd0);
        check({name, ".done"},   32'(vif.done), 32'd0);
        check({name, ".ovf"},    32'(vif.ovf),  32'd0);
    endtask

    initial begin
        logic any_busy;
        rst            = 1'b1;
        vif.start      = 1'b0;
        vif.center_x   = '0;
        vif.center_y   = '0;
        vif.zoom_level = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        run_calc(32'hF800_0000, 32'h0, 5'd0, "tp_zoom0");
        check("tp_zoom0.lit_xmin", vif.xmin, 32'hD800_0000);
        check("tp_zoom0.lit_xmax", vif.xmax, 32'h1800_0000);
        check("tp_zoom0.lit_ymin", vif.ymin, 32'hE800_0000);
        check("tp_zoom0.lit_Xscale", vif.Xscale, 32'h0066_6666);
        check("tp_zoom0.lit_Yscale", vif.Yscale, 32'h0066_6666);
        drop_start("tp_zoom0");

        run_calc(32'h0, 32'h0, 5'd3, "tp_zoom3");
        check("tp_zoom3.lit_ymin", vif.ymin, 32'hFD00_0000);
        check("tp_zoom3.lit_Xscale", vif.Xscale, 32'h000C_CCCC);
        drop_start("tp_zoom3");

        run_calc(32'h7000_0000, 32'h0, 5'd0, "tp_sat");
        check("tp_sat.lit_xmax", vif.xmax, 32'h7FFF_FFFF);
        check("tp_sat.lit_ovf", 32'(vif.ovf), 32'd1);
        check("tp_sat.lit_Xscale", vif.Xscale, 32'h0066_6666);
        drop_start("tp_sat");

        run_calc(32'h0123_4567, 32'h0, 5'd31, "tp_clamp");
        check("tp_clamp.lit_xmin", vif.xmin, 32'h0123_4566);
        check("tp_clamp.lit_Yscale", vif.Yscale, 32'h0);
        drop_start("tp_clamp");

        // Abort 20 cycles into the X divide, then a fresh run must behave normally.
        @(negedge clk);
        vif.center_x   = 32'h1000_0000;
        vif.center_y   = 32'h0800_0000;
        vif.zoom_level = 5'd1;
        vif.start      = 1'b1;
        repeat (22) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        vif.start = 1'b0;
        @(posedge clk);
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        run_calc(32'hF000_0000, 32'h0400_0000, 5'd2, "after_reset");

        // Start held high: new inputs must not trigger a second computation.
        @(negedge clk);
        vif.center_x   = 32'h3000_0000;
        vif.center_y   = 32'hC000_0000;
        vif.zoom_level = 5'd7;
        any_busy = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            any_busy |= vif.busy;
        end
        check("hold.any_busy", 32'(any_busy), 32'd0);
        check("hold.done", 32'(vif.done), 32'd1);
        check_outputs("hold");
        drop_start("hold");
        run_calc(32'h3000_0000, 32'hC000_0000, 5'd7, "rearm");
        drop_start("rearm");

        for (int i = 0; i < 24; i++) begin
            run_calc($urandom, $urandom, 5'($urandom_range(0, 31)), $sformatf("rand%0d", i));
            drop_start($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdbrot_viewport_calc.md
# mdbrot_viewport_calc

Upstream stage of the Mandelbrot escape-time renderer: the block that implements the top level's scale-factor-calculation phase. On a start request it converts a view centre and power-of-two zoom level into the complex-plane window (xmin, xmax, ymin, ymax) and per-pixel step sizes (Xscale, Yscale) for the 160x120 VGA frame. Its outputs feed directly into the escape-time module's bound and scale inputs; its done flag gates that module's start.

## Interface
Parameters:
- H_RES, 160, horizontal pixel count (divisor for Xscale)
- V_RES, 120, vertical pixel count (divisor for Yscale)
- BASE_HALF_W, 32'h2000_0000, half-width of the view at zoom 0 (2.0 in Q4.28)

Ports (all numeric values are signed Q4.28 unless stated otherwise):
- clk  in  1  system clock (CLOCK_50 at top level)
- rst  in  1  reset; **one clock; reset is synchronous and active-high**
- start  in  1  request; level, sampled only in IDLE
- center_x  in  32  view centre, real part
- center_y  in  32  view centre, imaginary part
- zoom_level  in  5  unsigned; half-width = BASE_HALF_W >> zoom_level
- xmin, xmax, ymin, ymax  out  32 each  window bounds
- Xscale, Yscale  out  32 each  per-pixel step
- busy  out  1  high from BOUNDS through DIV_Y
- done  out  1  high in DONE; outputs valid and stable
- ovf  out  1  set if any bound saturated in the last computation

## Operation
- States: IDLE, BOUNDS, DIV_X, DIV_Y, DONE.
- **IDLE, start=1:** capture center_x, center_y and zoom_level; go to BOUNDS. Values of zoom_level ≥ 29 are clamped to 29.
- **BOUNDS (1 cycle):**
  - hw = BASE_HALF_W >> zoom; hh = (hw>>1) + (hw>>2), i.e. 3/4 aspect with truncation.
  - xmin = cx − hw; xmax = cx + hw; ymin = cy − hh; ymax = cy + hh.
  - Each sum is computed 33-bit and saturated to 32'h7FFF_FFFF / 32'h8000_0000; any saturation sets ovf.
  - Launch divider with dividend 2·hw (unsigned 32-bit) and divisor H_RES.
- **DIV_X (32 cycles):** serial restoring divide. On completion, Xscale = quotient (truncated); launch 2·hh / V_RES; go to DIV_Y.
- **DIV_Y (32 cycles):** Yscale = quotient; go to DONE.
- Scales derive from the unsaturated widths, never from the saturated bounds.
- **DONE:** done=1; stay while start=1; go to IDLE when start=0. All outputs hold their values through IDLE until the next capture.
- Outputs are registered. Bounds update at the end of BOUNDS; ovf is cleared on capture.
- start is ignored outside IDLE and DONE.

## Timing
- Reset: state=IDLE; all 32-bit outputs = 0; busy=0; done=0; ovf=0. The divider is cleared.
- Reset mid-computation aborts immediately, with the same values as reset.
- Latency:
  - Let E0 be the edge that samples start=1 in IDLE.
  - BOUNDS at E0→E1; DIV_X spans E2–E33; DIV_Y spans E34–E65.
  - done=1 after E65, i.e. 66 cycles after E0.
  - Bounds are valid after E1, Xscale after E33.
- busy=1 exactly from E0 until E65; busy and done are never high together.
- Start held high continuously produces one computation. A new one requires start low for at least one cycle, which takes DONE→IDLE.

## Structure
- Shared package mdbrot_pkg holds:
  - Q4.28 typedef fixed_t (logic signed [31:0]) and FRAC_BITS=28;
  - the state enum;
  - the H_RES/V_RES defaults;
  - a saturating add/sub function reused by the escape-time block.
- Sub-module mdbrot_serial_div: unsigned 32-bit ÷ 8-bit restoring divider.
  - Ports: clk, rst, go, dividend, divisor, busy, valid, quotient.
  - Takes exactly 32 cycles from go to valid.

## Test plan
- Centre (0xF800_0000 = −0.5, 0), zoom 0 → xmin 0xD800_0000, xmax 0x1800_0000, ymin 0xE800_0000, ymax 0x1800_0000, Xscale = Yscale = 0x0066_6666, ovf=0; done 66 cycles after start.
- Centre (0,0), zoom 3 → bounds 0xFC00_0000 / 0x0400_0000 / 0xFD00_0000 / 0x0300_0000; Xscale = Yscale = 0x000C_CCCC.
- center_x = 0x7000_0000, zoom 0 → xmax = 0x7FFF_FFFF, ovf=1, Xscale still 0x0066_6666.
- zoom_level 31 → treated as 29: hw=1, hh=0, Xscale=0, Yscale=0, xmin=cx−1.
- Assert rst at cycle 20 of DIV_X → next cycle all outputs 0 and state IDLE; a fresh start completes normally in 66 cycles.
- Hold start high after done and toggle inputs → outputs unchanged and no second computation; drop start then reassert → new result computed.
